uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 147 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Two-requester UART transmitter: 8N1 frames, round-robin arbitration on ties.
// All outputs registered; asynchronous active-high reset.
module uart_tx_arbiter #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [7:0] data0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned CW =
    ($clog2(CLKS_PER_BIT) < 1) ? 1 : $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          last_q, last_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          gnt0_q, gnt0_d;
  logic          gnt1_q, gnt1_d;
  logic          done0_q, done0_d;
  logic          done1_q, done1_d;
  logic          wrap;
  logic          pick1;

  assign wrap = (cnt_q == CNT_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      last_q  <= 1'b1;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      last_q  <= last_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    last_d  = last_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    // On a tie, requester 1 wins only if requester 0 was served last
    pick1   = req1 & (~req0 | ~last_q);

    if (state_q != IDLE) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d = START;
          cnt_d   = '0;
          bit_d   = '0;
          shift_d = pick1 ? data1 : data0;
          last_d  = pick1;
          gnt0_d  = ~pick1;
          gnt1_d  = pick1;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (wrap) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end
      end
      DATA: begin
        if (wrap) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
      STOP: begin
        if (wrap) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done0_d = ~last_q;
          done1_d = last_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign done0 = done0_q;
  assign done1 = done1_q;
  assign tx    = tx_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: table of single frames plus
// hand-written back-to-back, mid-frame request, data change and reset cases.
module tb_uart_tx_arbiter;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1;
  logic [7:0] data0, data1;
  logic       gnt0, gnt1, done0, done1, tx, busy;

  int total = 0;
  int bad   = 0;

  uart_tx_arbiter #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .req0  (req0),
    .data0 (data0),
    .req1  (req1),
    .data1 (data1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .done0 (done0),
    .done1 (done1),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Mutual-exclusion check on every cycle out of reset
  always @(negedge clk) begin
    if (!reset) begin
      total++;
      if ((gnt0 & gnt1) | (done0 & done1) | ((gnt0 | gnt1) & (done0 | done1))) begin
        bad++;
        $display("FAIL excl t=%0t gnt=%b%b done=%b%b required no overlap",
                 $time, gnt1, gnt0, done1, done0);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expects a grant on the very next edge; leaves time at E0+1
  task automatic wait_gnt(input string name, input int who);
    int n;
    tick();
    n = 1;
    while (!(gnt0 | gnt1) && n < 40) begin
      tick();
      n++;
    end
    chk({name, "_lat"}, n, 1);
    chk({name, "_who"}, {30'd0, gnt1, gnt0}, (who == 1) ? 2 : 1);
  endtask

  // Called at E0+1; checks every cycle up to and including the done edge
  task automatic check_frame(input string name, input int who,
                             input logic [7:0] b, input bit drop,
                             input bit poke, input int raise1_at);
    logic [5:0] act, exp, act_bad, exp_bad;
    bit         seen;
    logic       txe;
    seen = 0;
    act_bad = '0;
    exp_bad = '0;
    act = '0;
    exp = '0;
    for (int c = 0; c <= 10 * CPB; c++) begin
      if (c > 0) tick();
      if (c == 1 && poke) data0 = 8'hFF;
      if (c == raise1_at) req1 = 1'b1;
      if (c < CPB) txe = 1'b0;
      else if (c < 9 * CPB) txe = b[c / CPB - 1];
      else txe = 1'b1;
      exp = {txe, (c < 10 * CPB),
             (c == 0 && who == 0), (c == 0 && who == 1),
             (c == 10 * CPB && who == 0), (c == 10 * CPB && who == 1)};
      act = {tx, busy, gnt0, gnt1, done0, done1};
      if (act !== exp && !seen) begin
        seen = 1;
        act_bad = act;
        exp_bad = exp;
        $display("  %s first difference at cycle %0d", name, c);
      end
      if (c == 0 && drop) begin
        if (who == 0) req0 = 1'b0;
        else req1 = 1'b0;
      end
    end
    if (seen) chk(name, {26'd0, act_bad}, {26'd0, exp_bad});
    else chk(name, {26'd0, act}, {26'd0, exp});
  endtask

  typedef struct {
    logic       r0;
    logic       r1;
    logic [7:0] d0;
    logic [7:0] d1;
    int         who;
    logic [7:0] b;
  } vec_t;

  vec_t vt[6];

  initial begin
    vt[0] = '{1'b1, 1'b0, 8'hB3, 8'h00, 0, 8'hB3};
    vt[1] = '{1'b1, 1'b1, 8'h11, 8'h22, 1, 8'h22};
    vt[2] = '{1'b1, 1'b1, 8'h33, 8'h44, 0, 8'h33};
    vt[3] = '{1'b0, 1'b1, 8'h00, 8'hA5, 1, 8'hA5};
    vt[4] = '{1'b1, 1'b0, 8'hFF, 8'h00, 0, 8'hFF};
    vt[5] = '{1'b1, 1'b1, 8'h5A, 8'hC3, 1, 8'hC3};

    reset = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    data0 = 8'h00;
    data1 = 8'h00;
    #1;
    chk("rst_outs", {26'd0, tx, busy, gnt0, gnt1, done0, done1}, 6'b100000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;

    // Table: each row starts from IDLE, granted request dropped after grant
    for (int i = 0; i < 6; i++) begin
      req0 = vt[i].r0;
      req1 = vt[i].r1;
      data0 = vt[i].d0;
      data1 = vt[i].d1;
      wait_gnt($sformatf("row%0d", i), vt[i].who);
      req0 = 1'b0;
      req1 = 1'b0;
      check_frame($sformatf("row%0d_frame", i), vt[i].who, vt[i].b, 1'b0, 1'b0, -1);
    end

    // Both held for four frames after reset: 0,1,0,1 back to back
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req0 = 1'b1;
    req1 = 1'b1;
    data0 = 8'hCC;
    data1 = 8'h00;
    for (int k = 0; k < 4; k++) begin
      wait_gnt($sformatf("rr%0d", k), k % 2);
      check_frame($sformatf("rr%0d_frame", k), k % 2,
                  (k % 2) ? 8'h00 : 8'hCC, 1'b0, 1'b0, -1);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    chk("rr_idle_busy", {31'd0, busy}, 0);

    // req1 raised mid-frame of requester 0
    req0 = 1'b1;
    data0 = 8'h5A;
    data1 = 8'h77;
    wait_gnt("mid", 0);
    check_frame("mid_frame0", 0, 8'h5A, 1'b1, 1'b0, 50);
    wait_gnt("mid_g1", 1);
    check_frame("mid_frame1", 1, 8'h77, 1'b1, 1'b0, -1);

    // data0 changed after grant has no effect
    req0 = 1'b1;
    data0 = 8'h5A;
    wait_gnt("poke", 0);
    check_frame("poke_frame", 0, 8'h5A, 1'b1, 1'b1, -1);

    // Reset at E0+70 during DATA: immediate idle line, no done
    req0 = 1'b1;
    data0 = 8'h96;
    wait_gnt("abort", 0);
    req0 = 1'b0;
    repeat (69) tick();
    #2;
    chk("abort_pre_tx", {31'd0, tx}, 0);
    reset = 1'b1;
    #1;
    chk("abort_tx_busy", {30'd0, tx, busy}, 2'b10);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("abort_no_done", {30'd0, done0, done1}, 0);
    end
    @(negedge clk);
    reset = 1'b0;
    req0 = 1'b1;
    data0 = 8'h3C;
    #1;
    wait_gnt("post_rst", 0);
    check_frame("post_rst_frame", 0, 8'h3C, 1'b1, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
